// File: rtl/spi_shift_pkg.sv
// Shared definitions for the SPI shift stage.
//   SPI_CHAR_LEN      : default maximum character length in bits
//   SPI_CHAR_LEN_BITS : default width of the length code (0 encodes SPI_CHAR_LEN)
//   IDLE/SHIFT/DONE   : FSM state encodings
//   spi_dbg_t         : debug snapshot of the FSM state and both bit counters
package spi_shift_pkg;

  localparam int SPI_CHAR_LEN      = 32;
  localparam int SPI_CHAR_LEN_BITS = 5;
  localparam int SPI_CNT_W         = SPI_CHAR_LEN_BITS + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef struct packed {
    logic [1:0]           state;
    logic [SPI_CNT_W-1:0] tx_cnt;
    logic [SPI_CNT_W-1:0] rx_cnt;
  } spi_dbg_t;

endpackage

// File: rtl/spi_bit_cnt.sv
// Loadable down-counter used to track the bits still to be sent or received.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : load i_load_val (has priority over i_dec)
//   i_dec        : decrement by one; saturates at zero
//   o_cnt        : current count
//   o_is_one     : o_cnt == 1
//   o_is_zero    : o_cnt == 0
module spi_bit_cnt #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_is_one,
  output logic         o_is_zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt     = cnt_q;
  assign o_is_one  = (cnt_q == W'(1));
  assign o_is_zero = (cnt_q == '0);

endmodule

// File: rtl/spi_shift.sv
// SPI serialiser/deserialiser driven by the clock generator's edge pulses.
// Optional feature macro: SPI_LSB_FIRST_EN adds i_lsb (LSB-first ordering).
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_start          : request a transfer (accepted only in IDLE)
//   i_len            : character length code, 0 means DATA_W bits
//   i_tx_negedge     : MOSI advances on neg-edge pulse (else pos-edge)
//   i_rx_negedge     : MISO sampled on neg-edge pulse (else pos-edge)
//   i_pos_edge/i_neg_edge : SCLK edge pulses from the clock generator
//   i_tx_data        : word to transmit
//   i_miso           : serial input
//   i_lsb            : (SPI_LSB_FIRST_EN only) 1 = LSB first
//   o_mosi           : serial output
//   o_rx_data        : received word, right-justified, valid from o_done on
//   o_busy           : transfer in progress (generator enable)
//   o_last_clk       : final bit in flight (generator last-clock)
//   o_done           : one-cycle completion pulse
//   o_dbg            : FSM state and both counters
//
// Handshake: i_start is a one-cycle request with no ready signal; it is
// accepted only when the FSM is IDLE (o_busy=0 and o_done=0) and is
// silently dropped otherwise. i_len, i_tx_data, the edge-mode bits and i_lsb
// are captured on the accepting cycle and ignored for the rest of the transfer.
module spi_shift
  import spi_shift_pkg::*;
#(
  parameter int DATA_W = SPI_CHAR_LEN,
  parameter int LEN_W  = SPI_CHAR_LEN_BITS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_tx_negedge,
  input  logic              i_rx_negedge,
  input  logic              i_pos_edge,
  input  logic              i_neg_edge,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_miso,
`ifdef SPI_LSB_FIRST_EN
  input  logic              i_lsb,
`endif
  output logic              o_mosi,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_busy,
  output logic              o_last_clk,
  output logic              o_done,
  output spi_dbg_t          o_dbg
);

  localparam int               CNT_W    = LEN_W + 1;
  localparam logic [CNT_W-1:0] DATA_W_C = CNT_W'(DATA_W);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              mosi_q, mosi_d;
  logic              last_q, last_d;
  logic              tx_neg_q, tx_neg_d;
  logic              rx_neg_q, rx_neg_d;
  logic              lsb_q, lsb_d;
  logic [CNT_W-1:0]  len_n_q, len_n_d;

  logic              lsb_in;
  logic [CNT_W-1:0]  start_n;
  logic              tx_edge, rx_edge;
  logic              cnt_load, tx_dec, rx_dec;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;
  logic              tx_one, tx_zero, rx_one, rx_zero;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = i_lsb;
`else
  assign lsb_in = 1'b0;
`endif

  assign start_n  = (i_len == '0) ? DATA_W_C : {1'b0, i_len};
  assign tx_edge  = tx_neg_q ? i_neg_edge : i_pos_edge;
  assign rx_edge  = rx_neg_q ? i_neg_edge : i_pos_edge;
  assign cnt_load = (state_q == IDLE) && i_start;
  // tx_cnt stops at 1: the last bit stays on MOSI rather than shifting out.
  assign tx_dec   = (state_q == SHIFT) && tx_edge && !tx_one && !tx_zero;
  assign rx_dec   = (state_q == SHIFT) && rx_edge && !rx_zero;

  spi_bit_cnt #(.W(CNT_W)) u_tx_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (cnt_load),
    .i_load_val (start_n),
    .i_dec      (tx_dec),
    .o_cnt      (tx_cnt),
    .o_is_one   (tx_one),
    .o_is_zero  (tx_zero)
  );

  spi_bit_cnt #(.W(CNT_W)) u_rx_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (cnt_load),
    .i_load_val (start_n),
    .i_dec      (rx_dec),
    .o_cnt      (rx_cnt),
    .o_is_one   (rx_one),
    .o_is_zero  (rx_zero)
  );

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    mosi_d    = mosi_q;
    tx_neg_d  = tx_neg_q;
    rx_neg_d  = rx_neg_q;
    lsb_d     = lsb_q;
    len_n_d   = len_n_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = SHIFT;
          // MSB-first: left-align the character so its MSB sits at the top.
          tx_sr_d  = lsb_in ? i_tx_data : (i_tx_data << (DATA_W_C - start_n));
          rx_sr_d  = '0;
          mosi_d   = lsb_in ? tx_sr_d[0] : tx_sr_d[DATA_W-1];
          tx_neg_d = i_tx_negedge;
          rx_neg_d = i_rx_negedge;
          lsb_d    = lsb_in;
          len_n_d  = start_n;
        end
      end
      SHIFT: begin
        if (tx_dec) begin
          tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
          mosi_d  = lsb_q ? tx_sr_d[0] : tx_sr_d[DATA_W-1];
        end
        if (rx_dec) begin
          // LSB-first fills from the top; realigned to bit 0 on completion.
          rx_sr_d = lsb_q ? {i_miso, rx_sr_q[DATA_W-1:1]}
                          : {rx_sr_q[DATA_W-2:0], i_miso};
          if (rx_one) begin
            state_d   = DONE;
            rx_data_d = lsb_q ? (rx_sr_d >> (DATA_W_C - len_n_q)) : rx_sr_d;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered copy of (state==SHIFT && tx_cnt==1), built from next values.
  always_comb begin
    last_d = 1'b0;
    if (state_d == SHIFT) begin
      if (cnt_load) begin
        last_d = (start_n == CNT_W'(1));
      end else if (tx_dec) begin
        last_d = (tx_cnt == CNT_W'(2));
      end else begin
        last_d = tx_one;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      mosi_q    <= 1'b0;
      last_q    <= 1'b0;
      tx_neg_q  <= 1'b0;
      rx_neg_q  <= 1'b0;
      lsb_q     <= 1'b0;
      len_n_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      mosi_q    <= mosi_d;
      last_q    <= last_d;
      tx_neg_q  <= tx_neg_d;
      rx_neg_q  <= rx_neg_d;
      lsb_q     <= lsb_d;
      len_n_q   <= len_n_d;
    end
  end

  assign o_mosi       = mosi_q;
  assign o_rx_data    = rx_data_q;
  assign o_busy       = (state_q == SHIFT);
  assign o_done       = (state_q == DONE);
  assign o_last_clk   = last_q;
  assign o_dbg.state  = state_q;
  assign o_dbg.tx_cnt = SPI_CNT_W'(tx_cnt);
  assign o_dbg.rx_cnt = SPI_CNT_W'(rx_cnt);

endmodule
